// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared encodings and constants for the instruction fetch controller and
// the next-PC unit reused by the core's PC logic.
package imem_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FS_BOOT   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

  localparam int          PC_STEP   = 4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/imem_pc_next.sv
// Combinational next-PC selection: jump over branch over sequential, with every
// result word aligned and folded into the DEPTH-word address space.
module imem_pc_next
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PC_W  = 8
) (
  input  logic [PC_W-1:0] cur_pc,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] next_pc,
  output logic            redirect
);

  // Keeps only the word-index bits, which both aligns and wraps the address.
  localparam logic [PC_W-1:0] ADDR_MASK =
    PC_W'(DEPTH * PC_STEP - 32'sd1) & ~PC_W'(2'b11);

  // Priority mux for the next fetch address.
  always_comb begin
    next_pc  = {PC_W{1'b0}};
    redirect = 1'b0;
    if (jmp) begin
      next_pc  = jmp_target & ADDR_MASK;
      redirect = 1'b1;
    end else if (br_taken) begin
      next_pc  = br_target & ADDR_MASK;
      redirect = 1'b1;
    end else begin
      next_pc  = (cur_pc + PC_W'(PC_STEP)) & ADDR_MASK;
      redirect = 1'b0;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: boot-time program load, then PC-driven fetch
// with stall, branch/jump squash and halt, presenting a registered instruction.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int              DEPTH    = 32,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_valid,
  input  logic [31:0]     ld_data,
  output logic            ld_ready,
  input  logic            ld_done,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [1:0]      state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  fetch_state_e     state_r, state_nxt_s;
  logic [PTR_W-1:0] ptr_r, ptr_nxt_s;
  logic [PC_W-1:0]  fetch_pc_r, fetch_pc_nxt_s;
  logic [PC_W-1:0]  pc_r, pc_nxt_s;
  logic [31:0]      instr_r, instr_nxt_s;
  logic             instr_valid_r, instr_valid_nxt_s;
  logic [PC_W-1:0]  next_pc_s;
  logic             redirect_s;
  logic             xfer_s;

  imem_pc_next #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_pc_next (
    .cur_pc     (fetch_pc_r),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .next_pc    (next_pc_s),
    .redirect   (redirect_s)
  );

  // Next-state and memory-port decode for the boot/run/halted sequencer.
  always_comb begin
    state_nxt_s       = state_r;
    ptr_nxt_s         = ptr_r;
    fetch_pc_nxt_s    = fetch_pc_r;
    pc_nxt_s          = pc_r;
    instr_nxt_s       = instr_r;
    instr_valid_nxt_s = instr_valid_r;
    xfer_s            = 1'b0;
    ld_ready          = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = fetch_pc_r;
    mem_wdata         = 32'h0000_0000;
    case (state_r)
      FS_BOOT: begin
        // Reset gating keeps the loader handshake quiet while reset is held.
        ld_ready          = (ptr_r < PTR_W'(DEPTH)) && !reset;
        xfer_s            = ld_valid && ld_ready;
        mem_we            = xfer_s;
        mem_addr          = PC_W'({ptr_r[IDX_W-1:0], 2'b00});
        mem_wdata         = ld_data;
        instr_valid_nxt_s = 1'b0;
        if (xfer_s) begin
          ptr_nxt_s = ptr_r + PTR_W'(1);
        end else begin
          ptr_nxt_s = ptr_r;
        end
        if (ld_done) begin
          state_nxt_s    = FS_RUN;
          fetch_pc_nxt_s = RESET_PC;
        end else begin
          state_nxt_s = FS_BOOT;
        end
      end
      FS_RUN: begin
        if (halt) begin
          state_nxt_s       = FS_HALTED;
          instr_valid_nxt_s = 1'b0;
        end else if (redirect_s) begin
          // The word fetched this cycle belongs to the abandoned path.
          fetch_pc_nxt_s    = next_pc_s;
          instr_nxt_s       = INSTR_NOP;
          instr_valid_nxt_s = 1'b0;
        end else if (stall) begin
          fetch_pc_nxt_s    = fetch_pc_r;
          instr_valid_nxt_s = instr_valid_r;
        end else begin
          instr_nxt_s       = mem_rdata;
          pc_nxt_s          = fetch_pc_r;
          instr_valid_nxt_s = 1'b1;
          fetch_pc_nxt_s    = next_pc_s;
        end
      end
      FS_HALTED: begin
        state_nxt_s       = FS_HALTED;
        instr_valid_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s       = FS_BOOT;
        instr_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= FS_BOOT;
      ptr_r         <= {PTR_W{1'b0}};
      fetch_pc_r    <= RESET_PC;
      pc_r          <= RESET_PC;
      instr_r       <= INSTR_NOP;
      instr_valid_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      ptr_r         <= ptr_nxt_s;
      fetch_pc_r    <= fetch_pc_nxt_s;
      pc_r          <= pc_nxt_s;
      instr_r       <= instr_nxt_s;
      instr_valid_r <= instr_valid_nxt_s;
    end
  end

  assign pc          = pc_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign state       = state_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a word-indexed reference model queues
// expected port values each cycle; two monitors pop and compare them.
module tb_imem_fetch_ctrl;

  localparam int DEPTH = 32;
  localparam int PC_W  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            ld_valid;
  logic [31:0]     ld_data;
  logic            ld_ready;
  logic            ld_done;
  logic            mem_we;
  logic [PC_W-1:0] mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;
  logic            stall;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            jmp;
  logic [PC_W-1:0] jmp_target;
  logic            halt;
  logic [PC_W-1:0] pc;
  logic [31:0]     instr;
  logic            instr_valid;
  logic [1:0]      state;

  imem_fetch_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .halt(halt), .pc(pc), .instr(instr), .instr_valid(instr_valid), .state(state)
  );

  always #5 clk = ~clk;

  // Instruction memory seen by the DUT: synchronous write, combinational read.
  logic [31:0] imem [DEPTH];
  assign mem_rdata = imem[mem_addr[6:2]];
  always @(posedge clk) if (mem_we) imem[mem_addr[6:2]] <= mem_wdata;

  typedef struct {
    logic        ready;
    logic        we;
    logic        chk_addr;
    logic [7:0]  addr;
    logic [31:0] data;
  } comb_t;

  typedef struct {
    logic [1:0]  st;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        valid;
  } reg_t;

  comb_t cq[$];
  reg_t  rq[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: word indices and plain arithmetic.
  int          m_state;   // 0 boot, 1 run, 2 halted
  int          m_ptr;
  int          m_fetch;   // word index being fetched
  logic [7:0]  m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [31:0] mdl_mem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Combinational outputs, sampled 1 time unit after the driving edge.
  always @(negedge clk) begin
    comb_t c;
    #1;
    if (cq.size() > 0) begin
      c = cq.pop_front();
      check("ld_ready", 32'(ld_ready), 32'(c.ready));
      check("mem_we", 32'(mem_we), 32'(c.we));
      if (c.chk_addr) check("mem_addr", 32'(mem_addr), 32'(c.addr));
      if (c.we) check("mem_wdata", mem_wdata, c.data);
    end
  end

  // Registered outputs, sampled shortly after the active edge.
  always @(posedge clk) begin
    reg_t r;
    #2;
    if (rq.size() > 0) begin
      r = rq.pop_front();
      check("state", 32'(state), 32'(r.st));
      check("pc", 32'(pc), 32'(r.pc));
      check("instr_valid", 32'(instr_valid), 32'(r.valid));
      check("instr", instr, r.instr);
    end
  end

  // Model one clock with the inputs currently driven, queue expectations, advance.
  task automatic tick();
    comb_t c;
    reg_t  r;
    c.ready = 1'b0; c.we = 1'b0; c.chk_addr = 1'b0; c.addr = 8'h00; c.data = 32'h0;
    if (!reset) begin
      if (m_state == 0) begin
        c.ready    = (m_ptr < DEPTH);
        c.we       = ld_valid && c.ready;
        c.addr     = 8'(m_ptr * 4);
        c.data     = ld_data;
        c.chk_addr = c.we;
      end else begin
        c.chk_addr = 1'b1;
        c.addr     = 8'(m_fetch * 4);
      end
    end
    cq.push_back(c);
    if (reset) begin
      m_state = 0; m_ptr = 0; m_fetch = 0; m_pc = 8'h00; m_instr = 32'h0; m_valid = 1'b0;
    end else if (m_state == 0) begin
      if (c.we) begin
        mdl_mem[m_ptr] = ld_data;
        m_ptr++;
      end
      if (ld_done) begin
        m_state = 1;
        m_fetch = 0;
      end
    end else if (m_state == 1) begin
      if (halt) begin
        m_state = 2;
        m_valid = 1'b0;
      end else if (jmp || br_taken) begin
        m_fetch = ((jmp ? int'(jmp_target) : int'(br_target)) / 4) % DEPTH;
        m_instr = 32'h0;
        m_valid = 1'b0;
      end else if (!stall) begin
        m_pc    = 8'(m_fetch * 4);
        m_instr = mdl_mem[m_fetch];
        m_valid = 1'b1;
        m_fetch = (m_fetch + 1) % DEPTH;
      end
    end
    r.st = 2'(m_state); r.pc = m_pc; r.instr = m_instr; r.valid = m_valid;
    rq.push_back(r);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; ld_valid = 1'b0; ld_data = 32'h0; ld_done = 1'b0;
    stall = 1'b0; br_taken = 1'b0; br_target = 8'h00; jmp = 1'b0; jmp_target = 8'h00;
    halt = 1'b0;
  endtask

  task automatic do_reset(input int n);
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  task automatic run_seq(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [31:0] words4 [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    words4[0] = 32'h014B4820; words4[1] = 32'h01AE6022;
    words4[2] = 32'h01CF6824; words4[3] = 32'h01CF6825;
    for (int i = 0; i < DEPTH; i++) begin
      imem[i]    = 32'hDEAD_0000 | 32'(i);
      mdl_mem[i] = 32'hDEAD_0000 | 32'(i);
    end
    m_state = 0; m_ptr = 0; m_fetch = 0; m_pc = 8'h00; m_instr = 32'h0; m_valid = 1'b0;
    idle_inputs();
    @(negedge clk);

    // Four-word program, continuous ld_valid, then ld_done and sequential run.
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); ld_valid = 1'b1; ld_data = words4[i]; tick();
    end
    idle_inputs(); ld_done = 1'b1; tick();
    run_seq(6);

    // Full fill with ld_valid held past the end; stray halt/redirects in BOOT.
    do_reset(1);
    for (int i = 0; i < DEPTH + 3; i++) begin
      idle_inputs(); ld_valid = 1'b1; ld_data = $urandom;
      halt = ($urandom_range(0, 7) == 0); br_taken = ($urandom_range(0, 7) == 0);
      jmp = ($urandom_range(0, 7) == 0); br_target = 8'($urandom); jmp_target = 8'($urandom);
      tick();
    end
    idle_inputs(); ld_valid = 1'b1; ld_data = 32'hBAD0_0033; ld_done = 1'b1; tick();
    run_seq(DEPTH + 3);

    // Branch to misaligned target, then simultaneous jump and branch.
    idle_inputs(); jmp = 1'b1; jmp_target = 8'h00; tick();
    run_seq(2);
    idle_inputs(); br_taken = 1'b1; br_target = 8'h0A; tick();
    run_seq(3);
    idle_inputs(); jmp = 1'b1; jmp_target = 8'h31; br_taken = 1'b1; br_target = 8'h54; tick();
    run_seq(3);

    // Three-cycle stall mid-stream.
    idle_inputs(); stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    run_seq(4);

    // Randomised run traffic, including targets beyond the memory range.
    for (int i = 0; i < 300; i++) begin
      idle_inputs();
      stall      = ($urandom_range(0, 3) == 0);
      br_taken   = ($urandom_range(0, 11) == 0);
      jmp        = ($urandom_range(0, 19) == 0);
      br_target  = 8'($urandom);
      jmp_target = 8'($urandom);
      ld_valid   = $urandom_range(0, 1) == 1;
      ld_data    = $urandom;
      ld_done    = $urandom_range(0, 1) == 1;
      tick();
    end

    // Halt together with stall once pc reaches 0x10.
    idle_inputs(); jmp = 1'b1; jmp_target = 8'h00; tick();
    begin
      int budget;
      budget = 0;
      while (!(m_pc == 8'h10 && m_valid) && budget < 80) begin
        run_seq(1);
        budget++;
      end
      checks++;
      if (budget >= 80) begin
        errors++;
        $display("FAIL reach_pc10: model never reached pc 10 within %0d cycles", budget);
      end
    end
    idle_inputs(); halt = 1'b1; stall = 1'b1; tick();
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      stall = $urandom_range(0, 1) == 1; br_taken = $urandom_range(0, 1) == 1;
      jmp = $urandom_range(0, 1) == 1; halt = $urandom_range(0, 1) == 1;
      br_target = 8'($urandom); jmp_target = 8'($urandom);
      tick();
    end

    // Reset after two boot writes restarts the load at address 0.
    do_reset(1);
    for (int i = 0; i < 2; i++) begin
      idle_inputs(); ld_valid = 1'b1; ld_data = 32'hA5A5_0000 | 32'(i); tick();
    end
    idle_inputs(); reset = 1'b1; ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF; tick();
    idle_inputs(); tick();
    idle_inputs(); ld_valid = 1'b1; ld_data = 32'h1234_5678; tick();
    idle_inputs(); ld_done = 1'b1; tick();
    run_seq(4);

    // Zero-word boot still enters RUN.
    do_reset(1);
    idle_inputs(); ld_done = 1'b1; tick();
    run_seq(3);

    run_seq(2);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check("cq_drained", 32'(cq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
